// File: rtl/maxpool_sub_if.sv
// Handshake bundle for the 2x2 max-pool stage: conv result strobe in, pooled entries out.
interface maxpool_sub_if #(
    parameter int DATAW = 20,
    parameter int ADDRW = 12
) ();
    logic               en;
    logic               convDone;
    logic [ADDRW-1:0]   convAddr;
    logic [DATAW-1:0]   convK0;
    logic [DATAW-1:0]   convK1;
    logic               poolValid;
    logic               poolReady;
    logic [ADDRW-3:0]   poolAddr;
    logic [DATAW-1:0]   poolK0;
    logic [DATAW-1:0]   poolK1;
    logic               frameDone;
    logic               seqErr;
    logic               ovfErr;

    // Environment side: conv block plus layer-1 writer.
    modport master (
        output en, convDone, convAddr, convK0, convK1, poolReady,
        input  poolValid, poolAddr, poolK0, poolK1, frameDone, seqErr, ovfErr
    );

    // Pooling stage side.
    modport slave (
        input  en, convDone, convAddr, convK0, convK1, poolReady,
        output poolValid, poolAddr, poolK0, poolK1, frameDone, seqErr, ovfErr
    );
endinterface

// File: rtl/maxpool_sub.sv
// 2x2 / stride-2 max-pool stage behind the convolution block.
// Collects four conv strobes per window, keeps a signed running max per kernel,
// and pushes the pooled pair into a small first-word-fall-through FIFO.
//
//   state | meaning
//   ACC0  | waiting for window sample (r,c): load maxima and window address
//   ACC1  | waiting for (r,c+1): running max
//   ACC2  | waiting for (r+1,c): running max
//   ACC3  | waiting for (r+1,c+1): final max, push result
module maxpool_sub #(
    parameter int DATAW      = 20,
    parameter int ADDRW      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    maxpool_sub_if.slave  bus
);
    localparam logic [1:0] ACC0 = 2'd0;
    localparam logic [1:0] ACC1 = 2'd1;
    localparam logic [1:0] ACC2 = 2'd2;
    localparam logic [1:0] ACC3 = 2'd3;

    localparam int PAW  = ADDRW - 2;
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = PTRW + 1;

    logic [1:0]       quad_q, quad_d;
    logic [DATAW-1:0] max0_q, max0_d, max1_q, max1_d;
    logic [PAW-1:0]   win_q, win_d;
    logic [ADDRW-1:0] seq_q, seq_d;
    logic [ADDRW-1:0] exp_addr;
    logic             seq_err_q, seq_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic [PTRW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [9:0]       out_cnt_q, out_cnt_d;

    logic [PAW-1:0]   addr_mem [FIFO_DEPTH];
    logic [DATAW-1:0] k0_mem   [FIFO_DEPTH];
    logic [DATAW-1:0] k1_mem   [FIFO_DEPTH];

    logic             strobe, push, do_push, pop, full, valid;
    logic [DATAW-1:0] res0, res1;

    // Signed max; a tie keeps the earlier (held) value.
    function automatic logic [DATAW-1:0] smax(input logic [DATAW-1:0] held,
                                              input logic [DATAW-1:0] cand);
        return ($signed(cand) > $signed(held)) ? cand : held;
    endfunction

    assign strobe = bus.en & bus.convDone;
    assign res0   = smax(max0_q, bus.convK0);
    assign res1   = smax(max1_q, bus.convK1);

    // Sequence index is {col[5:1], row[5:0], col[0]}, so a plain increment walks the
    // fixed input order and wraps after (63,63).
    assign exp_addr = {seq_q[6:1], seq_q[11:7], seq_q[0]};

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == CNTW'(FIFO_DEPTH));
    assign pop     = valid & bus.poolReady;
    assign do_push = push & (!full | pop);

    // Window accumulator FSM; dropping en abandons any partial window.
    always_comb begin
        quad_d = quad_q;
        max0_d = max0_q;
        max1_d = max1_q;
        win_d  = win_q;
        push   = 1'b0;
        if (!bus.en) begin
            quad_d = ACC0;
        end else if (bus.convDone) begin
            case (quad_q)
                ACC0: begin
                    max0_d = bus.convK0;
                    max1_d = bus.convK1;
                    win_d  = {bus.convAddr[11:7], bus.convAddr[5:1]};
                    quad_d = ACC1;
                end
                ACC1: begin
                    max0_d = res0;
                    max1_d = res1;
                    quad_d = ACC2;
                end
                ACC2: begin
                    max0_d = res0;
                    max1_d = res1;
                    quad_d = ACC3;
                end
                ACC3: begin
                    push   = 1'b1;
                    quad_d = ACC0;
                end
                default: quad_d = ACC0;
            endcase
        end
    end

    // Expected-address tracker, sticky order error, FIFO pointers and pop counter.
    always_comb begin
        seq_d     = seq_q;
        seq_err_d = seq_err_q;
        ovf_err_d = ovf_err_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        if (strobe) begin
            seq_d = seq_q + ADDRW'(1);
            if (bus.convAddr != exp_addr) seq_err_d = 1'b1;
        end
        if (push && full && !pop) ovf_err_d = 1'b1;
        if (do_push) wr_d = wr_q + PTRW'(1);
        if (pop) begin
            rd_d      = rd_q + PTRW'(1);
            out_cnt_d = out_cnt_q + 10'd1;
        end
        if (do_push && !pop)      cnt_d = cnt_q + CNTW'(1);
        else if (!do_push && pop) cnt_d = cnt_q - CNTW'(1);
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            quad_q    <= ACC0;
            max0_q    <= '0;
            max1_q    <= '0;
            win_q     <= '0;
            seq_q     <= '0;
            seq_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            quad_q    <= quad_d;
            max0_q    <= max0_d;
            max1_q    <= max1_d;
            win_q     <= win_d;
            seq_q     <= seq_d;
            seq_err_q <= seq_err_d;
            ovf_err_q <= ovf_err_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_q] <= win_q;
            k0_mem[wr_q]   <= res0;
            k1_mem[wr_q]   <= res1;
        end
    end

    assign bus.poolValid = valid;
    assign bus.poolAddr  = valid ? addr_mem[rd_q] : '0;
    assign bus.poolK0    = valid ? k0_mem[rd_q]   : '0;
    assign bus.poolK1    = valid ? k1_mem[rd_q]   : '0;
    assign bus.frameDone = pop & (out_cnt_q == 10'd1023);
    assign bus.seqErr    = seq_err_q;
    assign bus.ovfErr    = ovf_err_q;
endmodule

// File: tb/tb_maxpool_sub.sv
// Directed bench for maxpool_sub: hand-computed windows, a full frame, overflow,
// order errors, en drop and mid-drain reset.
module tb_maxpool_sub;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    maxpool_sub_if #(.DATAW(20), .ADDRW(12)) bus ();

    maxpool_sub #(.DATAW(20), .ADDRW(12), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk_addr(input int r, input int c);
        logic [5:0] rr;
        logic [5:0] cc;
        rr = r[5:0];
        cc = c[5:0];
        return {rr, cc};
    endfunction

    // One conv strobe, driven and released on falling edges; returns just after the capture edge.
    task automatic strobe(input int r, input int c, input logic [19:0] k0, input logic [19:0] k1);
        @(negedge clk);
        bus.convDone = 1'b1;
        bus.convAddr = mk_addr(r, c);
        bus.convK0   = k0;
        bus.convK1   = k1;
        @(negedge clk);
        bus.convDone = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, bus.poolValid, 0);
        check({tag, "_addr"},  bus.poolAddr,  0);
        check({tag, "_k0"},    bus.poolK0,    0);
        check({tag, "_k1"},    bus.poolK1,    0);
        check({tag, "_fdone"}, bus.frameDone, 0);
        check({tag, "_seq"},   bus.seqErr,    0);
        check({tag, "_ovf"},   bus.ovfErr,    0);
    endtask

    initial begin
        int k;
        bus.en        = 1'b1;
        bus.convDone  = 1'b0;
        bus.convAddr  = '0;
        bus.convK0    = '0;
        bus.convK1    = '0;
        bus.poolReady = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_idle("rst");

        // Window (0,0): K0 max is the second sample.
        strobe(0, 0, 20'h01000, 20'h00000);
        strobe(0, 1, 20'h03000, 20'h00000);
        strobe(1, 0, 20'h02000, 20'h00000);
        check("w0_early_valid", bus.poolValid, 0);
        strobe(1, 1, 20'h00800, 20'h00000);
        check("w0_valid", bus.poolValid, 1);
        check("w0_addr",  bus.poolAddr,  0);
        check("w0_k0",    bus.poolK0,    20'h03000);
        @(negedge clk);
        check("w0_gone",  bus.poolValid, 0);

        // Window (2,0): mixed-sign K0 and all-negative K1; signed max differs from unsigned for K0.
        strobe(2, 0, 20'h10000, 20'hF8000);
        strobe(2, 1, 20'hF0000, 20'hFC000);
        strobe(3, 0, 20'h80000, 20'hFA000);
        strobe(3, 1, 20'h7FFFF, 20'hFF000);
        check("w1_valid", bus.poolValid, 1);
        check("w1_addr",  bus.poolAddr,  10'd32);
        check("w1_k0",    bus.poolK0,    20'h7FFFF);
        check("w1_k1",    bus.poolK1,    20'hFF000);
        check("w1_seq",   bus.seqErr,    0);

        // Full frame in input order; K0 rises so its max is the last sample,
        // K1 falls (all negative) so its max is the first sample.
        do_reset();
        k = 0;
        for (int cp = 0; cp < 32; cp++) begin
            for (int rp = 0; rp < 32; rp++) begin
                int first_i;
                int last_i;
                first_i = cp * 128 + rp * 4;
                for (int rr = 0; rr < 2; rr++) begin
                    for (int c0 = 0; c0 < 2; c0++) begin
                        int row;
                        int idx;
                        row = 2 * rp + rr;
                        idx = cp * 128 + row * 2 + c0;
                        strobe(row, 2 * cp + c0, 20'(idx), 20'hFFFFF - 20'(idx));
                    end
                end
                last_i = first_i + 3;
                check("fr_valid", bus.poolValid, 1);
                check("fr_addr",  bus.poolAddr,  {rp[4:0], cp[4:0]});
                check("fr_k0",    bus.poolK0,    20'(last_i));
                check("fr_k1",    bus.poolK1,    20'hFFFFF - 20'(first_i));
                check("fr_fdone", bus.frameDone, (k == 1023) ? 1 : 0);
                k++;
            end
        end
        @(negedge clk);
        check("fr_fdone_after", bus.frameDone, 0);
        check("fr_empty",       bus.poolValid, 0);
        check("fr_seq",         bus.seqErr,    0);
        check("fr_ovf",         bus.ovfErr,    0);

        // Backpressure: three windows into a 2-entry FIFO, third dropped.
        do_reset();
        bus.poolReady = 1'b0;
        for (int w = 0; w < 3; w++) begin
            strobe(2 * w,     0, 20'(16 * w + 1), 20'(16 * w + 8));
            strobe(2 * w,     1, 20'(16 * w + 5), 20'(16 * w + 2));
            strobe(2 * w + 1, 0, 20'(16 * w + 3), 20'(16 * w + 4));
            strobe(2 * w + 1, 1, 20'(16 * w + 2), 20'(16 * w + 6));
            check("bp_valid", bus.poolValid, 1);
            check("bp_addr",  bus.poolAddr,  0);
            check("bp_k0",    bus.poolK0,    20'd5);
            check("bp_k1",    bus.poolK1,    20'd8);
            check("bp_ovf",   bus.ovfErr,    (w == 2) ? 1 : 0);
        end
        bus.poolReady = 1'b1;
        @(negedge clk);
        check("bp_d1_addr", bus.poolAddr, 10'd32);
        check("bp_d1_k0",   bus.poolK0,   20'd21);
        check("bp_d1_k1",   bus.poolK1,   20'd24);
        @(negedge clk);
        check("bp_empty",   bus.poolValid, 0);
        check("bp_ovf_sticky", bus.ovfErr, 1);

        // Out-of-order strobe sets a sticky seqErr.
        do_reset();
        strobe(0, 0, 20'd1, 20'd1);
        check("seq_ok", bus.seqErr, 0);
        strobe(0, 2, 20'd1, 20'd1);
        check("seq_set", bus.seqErr, 1);
        repeat (5) @(negedge clk);
        strobe(1, 0, 20'd1, 20'd1);
        check("seq_sticky", bus.seqErr, 1);

        // en drop discards a partial window; then reset while an entry is queued.
        do_reset();
        bus.poolReady = 1'b0;
        strobe(0, 0, 20'd1, 20'd1);
        strobe(0, 1, 20'd2, 20'd2);
        strobe(1, 0, 20'd3, 20'd3);
        strobe(1, 1, 20'd4, 20'd4);
        strobe(2, 0, 20'd9, 20'd9);
        strobe(2, 1, 20'd9, 20'd9);
        strobe(3, 0, 20'd9, 20'd9);
        strobe(3, 1, 20'd9, 20'd9);
        strobe(4, 0, 20'h7FFFF, 20'h7FFFF);
        strobe(4, 1, 20'h7FFFF, 20'h7FFFF);
        bus.en = 1'b0;
        strobe(40, 40, 20'd7, 20'd7);
        bus.en = 1'b1;
        bus.poolReady = 1'b1;
        @(negedge clk);
        bus.poolReady = 1'b0;
        check("en_head1", bus.poolAddr, 10'd32);
        strobe(5, 0, 20'd11, 20'd12);
        strobe(5, 1, 20'd13, 20'd10);
        check("en_seq", bus.seqErr, 0);
        check("en_ovf", bus.ovfErr, 0);
        bus.poolReady = 1'b1;
        @(negedge clk);
        bus.poolReady = 1'b0;
        check("en_partial_none", bus.poolValid, 0);
        strobe(6, 0, 20'd5, 20'd5);
        strobe(6, 1, 20'd5, 20'd5);
        check("en_new_valid", bus.poolValid, 1);
        check("en_new_addr",  bus.poolAddr,  10'd64);
        check("en_new_k0",    bus.poolK0,    20'd13);
        check("en_new_k1",    bus.poolK1,    20'd12);
        do_reset();
        check_idle("mid_rst");
        @(negedge clk);
        check("mid_rst_empty", bus.poolValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
